// File: rtl/add_tree_q88.sv
// -----------------------------------------------------------------------------
// add_tree_q88
//   Pipelined binary adder tree that reduces N unsigned Q8.8 lanes to one
//   saturated Q8.8 sum (the softmax denominator).
//   A companion vector and a valid bit travel through a delay line of matching
//   depth, so out_prop and valid_out stay aligned with out.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears every register
//   en         pipeline advance enable; 0 holds every stage
//   valid_in   input vector valid
//   in_0_flat  N*16 companion vector; delayed, not summed
//   in_1_flat  N*16 operand vector; lane i = bits[16i+15:16i], unsigned Q8.8
//   out        saturated sum of the N in_1 lanes, L = log2(N) cycles later
//   out_prop   in_0_flat delayed by L cycles
//   valid_out  valid_in delayed by L cycles
// -----------------------------------------------------------------------------
module add_tree_q88 #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            valid_in,
  input  logic [N*16-1:0] in_0_flat,
  input  logic [N*16-1:0] in_1_flat,
  output logic [15:0]     out,
  output logic [N*16-1:0] out_prop,
  output logic            valid_out
);

  localparam int DATA_W = 16;
  localparam int L      = $clog2(N);
  localparam int NODES  = N - 1;

  // Tree nodes are stored level by level in one flat array: level 1 occupies
  // indices [0, N/2), level 2 the next N/4 entries, and so on. The final node
  // (index N-2) is the registered output of level L.
  logic [DATA_W-1:0] node_q [0:NODES-1];
  logic [DATA_W-1:0] node_d [0:NODES-1];

  logic [N*16-1:0]   prop_q [1:L];
  logic [N*16-1:0]   prop_d [1:L];

  logic [L:1]        vld_q;
  logic [L:1]        vld_d;

  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  // Unsigned add computed one bit wider; a carry-out clamps to full scale.
  // Clamping at every level still yields min(true sum, FFFF) because the
  // saturated partial sum can only grow or stay clamped further up the tree.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  // Index of the first node of level k (k >= 1) in the flat node array.
  function automatic int lvl_off(input int k);
    return N - (N >> (k - 1));
  endfunction

  always_comb begin
    node_d = node_q;
    prop_d = prop_q;
    vld_d  = vld_q;
    opa    = '0;
    opb    = '0;
    if (en) begin
      for (int k = 1; k <= L; k++) begin
        for (int j = 0; j < N / 2; j++) begin
          if (j < (N >> k)) begin
            if (k == 1) begin
              opa = in_1_flat[32*j      +: DATA_W];
              opb = in_1_flat[32*j + 16 +: DATA_W];
            end else begin
              opa = node_q[lvl_off(k - 1) + 2*j];
              opb = node_q[lvl_off(k - 1) + 2*j + 1];
            end
            node_d[lvl_off(k) + j] = sat_add(opa, opb);
          end
        end
      end
      prop_d[1] = in_0_flat;
      vld_d[1]  = valid_in;
      for (int k = 2; k <= L; k++) begin
        prop_d[k] = prop_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
    end
  end

  // Stage boundary: every tree level, companion stage and valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) begin
        node_q[i] <= '0;
      end
      for (int k = 1; k <= L; k++) begin
        prop_q[k] <= '0;
      end
      vld_q <= '0;
    end else begin
      node_q <= node_d;
      prop_q <= prop_d;
      vld_q  <= vld_d;
    end
  end

  assign out       = node_q[NODES-1];
  assign out_prop  = prop_q[L];
  assign valid_out = vld_q[L];

endmodule

// File: tb/tb_add_tree_q88.sv
module tb_add_tree_q88;

  localparam int N = 8;

  logic            clk;
  logic            rst;
  logic            en;
  logic            valid_in;
  logic [N*16-1:0] in_0_flat;
  logic [N*16-1:0] in_1_flat;
  logic [15:0]     out;
  logic [N*16-1:0] out_prop;
  logic            valid_out;

  int n_checks = 0;
  int n_fails  = 0;

  add_tree_q88 #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid_in  (valid_in),
    .in_0_flat (in_0_flat),
    .in_1_flat (in_1_flat),
    .out       (out),
    .out_prop  (out_prop),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*16-1:0] splat(input logic [15:0] v);
    logic [N*16-1:0] r;
    for (int i = 0; i < N; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  // Advance one rising edge, then move 1 ns past it for driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N*16-1:0] obs,
                     input logic [N*16-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_out,
                         input logic [N*16-1:0] e_prop, input logic e_vld);
    chk({tag, ".out"},   {{(N*16-16){1'b0}}, out}, {{(N*16-16){1'b0}}, e_out});
    chk({tag, ".prop"},  out_prop, e_prop);
    chk({tag, ".valid"}, {{(N*16-1){1'b0}}, valid_out}, {{(N*16-1){1'b0}}, e_vld});
  endtask

  task automatic idle_inputs();
    valid_in  = 1'b0;
    in_0_flat = '0;
    in_1_flat = '0;
  endtask

  logic [N*16-1:0] v1;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    idle_inputs();
    #3;
    chk_all("reset", 16'h0000, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;

    // Test 1 + 6: ramp vector, valid for a single cycle
    for (int i = 0; i < N; i++) v1[16*i +: 16] = 16'((i + 1) * 256);
    in_1_flat = v1;
    in_0_flat = {{(N*16-16){1'b0}}, 16'd23};
    valid_in  = 1'b1;
    step();
    idle_inputs();
    step();
    chk("t1.valid_early", {{(N*16-1){1'b0}}, valid_out}, '0);
    step();
    chk_all("t1", 16'h2400, {{(N*16-16){1'b0}}, 16'h0017}, 1'b1);
    step();
    chk_all("t6.after", 16'h0000, '0, 1'b0);

    // Test 2: saturation then small values, back to back
    in_1_flat = splat(16'h4000);
    valid_in  = 1'b1;
    step();
    in_1_flat = splat(16'h0001);
    step();
    idle_inputs();
    step();
    chk_all("t2.sat", 16'hFFFF, '0, 1'b1);
    step();
    chk_all("t2.small", 16'h0008, '0, 1'b1);
    in_1_flat = splat(16'h1FFF);
    valid_in  = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    chk_all("t2.nosat", 16'hFFF8, '0, 1'b1);

    // Test 3: streaming A then B with companions
    in_1_flat = splat(16'h0100);
    in_0_flat = splat(16'hA5A5);
    valid_in  = 1'b1;
    step();
    in_1_flat = splat(16'h0200);
    in_0_flat = splat(16'h5A5A);
    step();
    idle_inputs();
    step();
    chk_all("t3.A", 16'h0800, splat(16'hA5A5), 1'b1);
    step();
    chk_all("t3.B", 16'h1000, splat(16'h5A5A), 1'b1);
    step();
    chk_all("t3.flush", 16'h0000, '0, 1'b0);

    // Test 4: stall two cycles with a vector mid-pipe
    in_1_flat = splat(16'h0300);
    in_0_flat = splat(16'hABCD);
    valid_in  = 1'b1;
    step();
    idle_inputs();
    step();
    en        = 1'b0;
    valid_in  = 1'b1;
    in_1_flat = splat(16'hFFFF);
    in_0_flat = splat(16'h1111);
    step();
    chk_all("t4.stall1", 16'h0000, '0, 1'b0);
    step();
    chk_all("t4.stall2", 16'h0000, '0, 1'b0);
    idle_inputs();
    en = 1'b1;
    step();
    chk_all("t4.resume", 16'h1800, splat(16'hABCD), 1'b1);
    step();
    chk_all("t4.after", 16'h0000, '0, 1'b0);

    // Test 5: asynchronous reset with data in flight
    in_1_flat = splat(16'h0100);
    in_0_flat = splat(16'h0D0D);
    valid_in  = 1'b1;
    step();
    in_1_flat = splat(16'h0080);
    in_0_flat = splat(16'h0E0E);
    step();
    idle_inputs();
    step();
    chk_all("t5.pre", 16'h0800, splat(16'h0D0D), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("t5.async", 16'h0000, '0, 1'b0);
    step();
    #2;
    rst = 1'b0;
    step();
    chk_all("t5.post1", 16'h0000, '0, 1'b0);
    step();
    chk_all("t5.post2", 16'h0000, '0, 1'b0);
    step();
    chk_all("t5.post3", 16'h0000, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
